// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write arbiter.
// Entry layout, arbiter FSM states and the one-hot register decoder.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ARB_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } arb_state_t;

    function automatic logic [31:0] onehot32(
        input logic [REG_ADDR_W-1:0] addr
    );
        logic [31:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Strict-order queue of pending multi-cycle writes.
// Exposes every slot plus a valid vector so the owner can build a pending mask.
module regfile_wr_fifo
    import regfile_arb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wr_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [CNT_W-1:0]       count_o,
    output entry_t [DEPTH-1:0]     entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot i is live when its distance from the read pointer is below the fill level.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs    = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, offs} < count_q);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (A) and a queued multi-cycle unit (B).
// Define REGFILE_ARB_BYPASS_EN to let B write straight through when A is idle and the queue is empty.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N            = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_A_RegWrite,
    input  logic [REG_ADDR_W-1:0] in_A_WriteReg_5,
    input  logic [N-1:0]          in_A_WriteData,
    input  logic                  in_B_Valid,
    output logic                  o_B_Ready,
    input  logic [REG_ADDR_W-1:0] in_B_WriteReg_5,
    input  logic [N-1:0]          in_B_WriteData,
    output logic                  o_RegWrite,
    output logic [REG_ADDR_W-1:0] o_WriteRegister_5,
    output logic [N-1:0]          o_WriteData,
    output logic [31:0]           o_Pending_32,
    output logic                  o_StallPipe
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [N-1:0]          data;
    } entry_t;

    entry_t             push_entry;
    entry_t             head;
    entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]   valid;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               full, empty;
    logic               a_wr, b_fire, b_keep;
    logic               bypass, push, pop, blocked;

    arb_state_t         state_q, state_d;
    logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic               stall_q, stall_d;

    assign a_wr    = in_A_RegWrite && (in_A_WriteReg_5 != '0);
    assign b_fire  = in_B_Valid && o_B_Ready;
    assign b_keep  = (in_B_WriteReg_5 != '0);
    assign o_B_Ready = !full;

`ifdef REGFILE_ARB_BYPASS_EN
    assign bypass  = b_fire && b_keep && !a_wr && empty;
`else
    assign bypass  = 1'b0;
`endif

    // Register-0 results complete the handshake but never occupy a slot.
    assign push    = b_fire && b_keep && !bypass;
    assign pop     = !a_wr && !empty;
    assign blocked = a_wr && !empty;

    assign push_entry = '{addr: in_B_WriteReg_5, data: in_B_WriteData};
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    regfile_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .entries_o   (entries),
        .valid_o     (valid)
    );

    always_comb begin
        o_RegWrite        = 1'b0;
        o_WriteRegister_5 = '0;
        o_WriteData       = '0;
        if (a_wr) begin
            o_RegWrite        = 1'b1;
            o_WriteRegister_5 = in_A_WriteReg_5;
            o_WriteData       = in_A_WriteData;
        end else if (pop) begin
            o_RegWrite        = 1'b1;
            o_WriteRegister_5 = head.addr;
            o_WriteData       = head.data;
        end else if (bypass) begin
            o_RegWrite        = 1'b1;
            o_WriteRegister_5 = in_B_WriteReg_5;
            o_WriteData       = in_B_WriteData;
        end
    end

    always_comb begin
        o_Pending_32 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                o_Pending_32 = o_Pending_32 | onehot32(entries[i].addr);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (count_next != '0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pop) begin
                    starve_cnt_d = '0;
                end else if (blocked) begin
                    starve_cnt_d = starve_cnt_q + SC_W'(1);
                    if (starve_cnt_d == SC_W'(STARVE_LIMIT)) begin
                        state_d = STARVED;
                    end
                end
            end
            STARVED: begin
                if (pop) begin
                    starve_cnt_d = '0;
                    state_d      = WAIT;
                end
            end
            default: begin
                state_d      = IDLE;
                starve_cnt_d = '0;
            end
        endcase
        if (count_next == '0) begin
            state_d      = IDLE;
            starve_cnt_d = '0;
        end
        stall_d = (state_d == STARVED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
        end
    end

    assign o_StallPipe = stall_q;

endmodule
